// File: rtl/npc_pc_unit.sv
// F-stage PC register and next-PC selector with a profiling return-address stack.
// Optional NPC_ALIGN_CHECK_EN: sticky misaligned-jr detection and word-aligned jr targets.
module npc_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          RAS_DEPTH = 8,
    parameter int          CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             d_valid,
    input  logic [31:0]                      d_pc,
    input  logic [2:0]                       npc_op,
    input  logic                             br_take,
    input  logic [25:0]                      imm26,
    input  logic [31:0]                      rs_data,
    input  logic                             jr_ra,
    output logic [31:0]                      f_pc,
    output logic [31:0]                      npc,
    output logic [31:0]                      ras_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_cnt,
    output logic [CNT_W-1:0]                 ras_hit_cnt,
    output logic [CNT_W-1:0]                 ras_miss_cnt,
    output logic                             align_err,
    output logic [31:0]                      err_addr
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int RC_W  = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] OP_SEQ    = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_JREG   = 3'd3;
    localparam logic [2:0] OP_JAL    = 3'd4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [31:0]      ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_wp;
    logic [2:0]       op_eff;
    logic [31:0]      br_off;
    logic [31:0]      jr_target;
    logic             do_push;
    logic             do_pop;
    logic             ras_match;

    always_comb begin
        op_eff = d_valid ? npc_op : OP_SEQ;
        br_off = {{14{imm26[15]}}, imm26[15:0], 2'b00};
`ifdef NPC_ALIGN_CHECK_EN
        jr_target = {rs_data[31:2], 2'b00};
`else
        jr_target = rs_data;
`endif
        case (op_eff)
            OP_BRANCH: npc = br_take ? d_pc + 32'd4 + br_off : f_pc + 32'd4;
            OP_JUMP,
            OP_JAL:    npc = {d_pc[31:28], imm26, 2'b00};
            OP_JREG:   npc = jr_target;
            default:   npc = f_pc + 32'd4;
        endcase
        // ras_wp points at the next free slot, so the top sits one below it
        ras_top   = (ras_cnt == '0) ? 32'd0 : ras_mem[ras_wp - 1'b1];
        do_push   = !stall && (op_eff == OP_JAL);
        do_pop    = !stall && (op_eff == OP_JREG) && jr_ra;
        ras_match = (ras_cnt != '0) && (ras_top == rs_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc         <= RESET_PC;
            ras_wp       <= '0;
            ras_cnt      <= '0;
            ras_hit_cnt  <= '0;
            ras_miss_cnt <= '0;
        end else if (!stall) begin
            f_pc <= npc;
            if (do_push) begin
                // when full the write slot holds the oldest entry
                ras_wp <= ras_wp + 1'b1;
                if (ras_cnt != RC_W'(RAS_DEPTH))
                    ras_cnt <= ras_cnt + 1'b1;
            end else if (do_pop) begin
                if (ras_match)
                    ras_hit_cnt <= sat_inc(ras_hit_cnt);
                else
                    ras_miss_cnt <= sat_inc(ras_miss_cnt);
                if (ras_cnt != '0) begin
                    ras_wp  <= ras_wp - 1'b1;
                    ras_cnt <= ras_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push)
            ras_mem[ras_wp] <= d_pc + 32'd8;
    end

`ifdef NPC_ALIGN_CHECK_EN
    logic misalign;
    assign misalign = (rs_data[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            align_err <= 1'b0;
            err_addr  <= 32'd0;
        end else if (!stall && (op_eff == OP_JREG) && misalign) begin
            if (!align_err)
                err_addr <= rs_data;
            align_err <= 1'b1;
        end
    end
`else
    assign align_err = 1'b0;
    assign err_addr  = 32'd0;
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// Self-checking bench for npc_pc_unit: directed steps followed by randomized cycles
// checked against a queue-based reference model.
module tb_npc_pc_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam int          RAS_DEPTH = 8;
    localparam int          CNT_W     = 4;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic                           clk = 1'b0;
    logic                           reset, stall, d_valid, br_take, jr_ra;
    logic [31:0]                    d_pc, rs_data;
    logic [2:0]                     npc_op;
    logic [25:0]                    imm26;
    logic [31:0]                    f_pc, npc, ras_top, err_addr;
    logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt;
    logic [CNT_W-1:0]               ras_hit_cnt, ras_miss_cnt;
    logic                           align_err;

    npc_pc_unit #(.RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .d_valid(d_valid), .d_pc(d_pc),
        .npc_op(npc_op), .br_take(br_take), .imm26(imm26), .rs_data(rs_data),
        .jr_ra(jr_ra), .f_pc(f_pc), .npc(npc), .ras_top(ras_top), .ras_cnt(ras_cnt),
        .ras_hit_cnt(ras_hit_cnt), .ras_miss_cnt(ras_miss_cnt),
        .align_err(align_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // reference model state
    logic [31:0] m_fpc;
    logic [31:0] m_ras[$];
    int          m_hit, m_miss;
    logic        m_aerr;
    logic [31:0] m_eaddr;

`ifdef NPC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_npc();
        logic [2:0]         op;
        logic signed [15:0] off16;
        op    = d_valid ? npc_op : 3'd0;
        off16 = imm26[15:0];
        case (op)
            3'd1:    return br_take ? d_pc + 32'd4 + 32'(int'(off16) * 4) : m_fpc + 32'd4;
            3'd2,
            3'd4:    return (d_pc & 32'hF000_0000) | (32'(imm26) << 2);
            3'd3:    return ALIGN_EN ? (rs_data & ~32'h3) : rs_data;
            default: return m_fpc + 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] model_top();
        return (m_ras.size() > 0) ? m_ras[$] : 32'd0;
    endfunction

    task automatic model_update(input logic [31:0] nxt);
        logic [2:0] op;
        op = d_valid ? npc_op : 3'd0;
        if (reset) begin
            m_fpc = RESET_PC; m_ras.delete(); m_hit = 0; m_miss = 0;
            m_aerr = 1'b0; m_eaddr = 32'd0;
        end else if (!stall) begin
            if (op == 3'd4) begin
                m_ras.push_back(d_pc + 32'd8);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end else if (op == 3'd3 && jr_ra) begin
                if (m_ras.size() > 0 && m_ras[$] == rs_data) begin
                    if (m_hit < CNT_MAX) m_hit++;
                end else if (m_miss < CNT_MAX) m_miss++;
                if (m_ras.size() > 0) void'(m_ras.pop_back());
            end
            if (ALIGN_EN && op == 3'd3 && rs_data[1:0] != 2'b00) begin
                if (!m_aerr) m_eaddr = rs_data;
                m_aerr = 1'b1;
            end
            m_fpc = nxt;
        end
    endtask

    // one clock: check npc mid-cycle, advance model at the edge, check state after it
    task automatic step(input string tag);
        logic [31:0] nxt;
        @(negedge clk);
        nxt = model_npc();
        if (!reset) chk({tag, "_npc"}, npc, nxt);
        @(posedge clk);
        model_update(nxt);
        #1;
        chk({tag, "_fpc"}, f_pc, m_fpc);
        chk({tag, "_rcnt"}, 32'(ras_cnt), 32'(m_ras.size()));
        chk({tag, "_rtop"}, ras_top, model_top());
        chk({tag, "_hit"}, 32'(ras_hit_cnt), 32'(m_hit));
        chk({tag, "_miss"}, 32'(ras_miss_cnt), 32'(m_miss));
        chk({tag, "_aerr"}, 32'(align_err), 32'(m_aerr));
        chk({tag, "_eaddr"}, err_addr, m_eaddr);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] dpc,
                         input logic [25:0] imm, input logic take, input logic [31:0] rs,
                         input logic jra);
        d_valid = v; npc_op = op; d_pc = dpc; imm26 = imm; br_take = take;
        rs_data = rs; jr_ra = jra;
    endtask

    initial begin
        m_fpc = 32'd0; m_hit = 0; m_miss = 0; m_aerr = 1'b0; m_eaddr = 32'd0;
        reset = 1'b1; stall = 1'b0;
        drive(1'b1, 3'd0, 32'd0, 26'd0, 1'b0, 32'd0, 1'b0);
        step("rst");
        chk("rst_fpc_lit", f_pc, 32'h0000_3000);
        chk("rst_rtop_lit", ras_top, 32'd0);
        reset = 1'b0;

        step("seq1"); chk("seq1_lit", f_pc, 32'h3004);
        step("seq2"); chk("seq2_lit", f_pc, 32'h3008);
        step("seq3"); chk("seq3_lit", f_pc, 32'h300C);

        drive(1'b1, 3'd1, 32'h3010, 26'h000FFFC, 1'b1, 32'd0, 1'b0);
        #1 chk("br_taken_lit", npc, 32'h3004);
        step("br_t");
        drive(1'b1, 3'd3, 32'h3000, 26'd0, 1'b0, 32'h3014, 1'b0);
        step("jr_plain");
        drive(1'b1, 3'd1, 32'h3010, 26'h000FFFC, 1'b0, 32'd0, 1'b0);
        #1 chk("br_nt_lit", npc, 32'h3018);
        step("br_nt");

        stall = 1'b1;
        drive(1'b1, 3'd2, 32'h3018, 26'h0000C10, 1'b0, 32'd0, 1'b0);
        step("stall1"); chk("stall1_lit", f_pc, 32'h3018);
        step("stall2"); chk("stall2_lit", f_pc, 32'h3018);
        stall = 1'b0;
        step("unstall"); chk("jump_lit", f_pc, 32'h0000_3040);

        drive(1'b0, 3'd2, 32'h3018, 26'h0000C10, 1'b0, 32'd0, 1'b0);
        #1 chk("bubble_lit", npc, 32'h3044);
        step("bubble");

        drive(1'b1, 3'd4, 32'h3020, 26'h0000C10, 1'b0, 32'd0, 1'b0);
        step("jal1"); chk("jal1_cnt_lit", 32'(ras_cnt), 32'd1);
        drive(1'b1, 3'd3, 32'h3024, 26'd0, 1'b0, 32'h3028, 1'b1);
        step("jr_hit"); chk("jr_hit_lit", 32'(ras_hit_cnt), 32'd1);
        chk("jr_hit_cnt_lit", 32'(ras_cnt), 32'd0);
        drive(1'b1, 3'd4, 32'h3020, 26'h0000C10, 1'b0, 32'd0, 1'b0);
        step("jal2");
        drive(1'b1, 3'd3, 32'h3024, 26'd0, 1'b0, 32'h4000, 1'b1);
        step("jr_miss"); chk("jr_miss_lit", 32'(ras_miss_cnt), 32'd1);

        for (int k = 0; k <= RAS_DEPTH; k++) begin
            drive(1'b1, 3'd4, 32'h3000 + 32'(16 * k), 26'h0000C10, 1'b0, 32'd0, 1'b0);
            step("fill");
        end
        chk("full_cnt_lit", 32'(ras_cnt), 32'(RAS_DEPTH));
        chk("full_top_lit", ras_top, 32'h3000 + 32'(16 * RAS_DEPTH) + 32'd8);
        for (int k = RAS_DEPTH; k >= 1; k--) begin
            drive(1'b1, 3'd3, 32'h3000, 26'd0, 1'b0, 32'h3000 + 32'(16 * k) + 32'd8, 1'b1);
            step("drain");
        end
        chk("drain_hits_lit", 32'(ras_hit_cnt), 32'(1 + RAS_DEPTH));
        drive(1'b1, 3'd3, 32'h3000, 26'd0, 1'b0, 32'h3008, 1'b1);
        step("empty_pop");
        chk("empty_miss_lit", 32'(ras_miss_cnt), 32'd2);
        chk("empty_cnt_lit", 32'(ras_cnt), 32'd0);

        drive(1'b1, 3'd3, 32'h3000, 26'd0, 1'b0, 32'h3006, 1'b0);
        #1 chk("mis_npc_lit", npc, ALIGN_EN ? 32'h3004 : 32'h3006);
        step("mis1");
        chk("mis1_aerr_lit", 32'(align_err), ALIGN_EN ? 32'd1 : 32'd0);
        chk("mis1_eaddr_lit", err_addr, ALIGN_EN ? 32'h3006 : 32'd0);
        drive(1'b1, 3'd3, 32'h3000, 26'd0, 1'b0, 32'h5002, 1'b0);
        step("mis2");
        chk("mis2_eaddr_lit", err_addr, ALIGN_EN ? 32'h3006 : 32'd0);
        reset = 1'b1;
        step("mis_rst");
        chk("mis_rst_aerr_lit", 32'(align_err), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < CNT_MAX + 2; k++) begin
            drive(1'b1, 3'd3, 32'h3000, 26'd0, 1'b0, 32'h6000, 1'b1);
            step("sat");
        end
        chk("sat_miss_lit", 32'(ras_miss_cnt), 32'(CNT_MAX));

        reset = 1'b1; step("rnd_rst"); reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            stall   = ($urandom_range(0, 99) < 15);
            reset   = (i == 400);
            d_valid = ($urandom_range(0, 99) < 80);
            npc_op  = 3'($urandom_range(0, 7));
            d_pc    = $urandom;
            imm26   = 26'($urandom);
            br_take = 1'($urandom);
            jr_ra   = ($urandom_range(0, 99) < 70);
            if (m_ras.size() > 0 && $urandom_range(0, 1) == 1) rs_data = m_ras[$];
            else rs_data = $urandom;
            step("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/npc_pc_unit.md
Name: npc_pc_unit

Overview:
Parametrised successor to the D-stage next-PC selector. It owns the F-stage PC register and selects the next PC from the D-stage decode: sequential, conditional branch, j/jal, or jr. It adds stall handling, D-stage bubble qualification and a return-address stack (RAS) with saturating hit/miss counters that profile jr $ra accuracy. It sits between the F-stage instruction fetch and the D-stage decode/compare logic.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
RAS_DEPTH, 8, RAS entries (power of 2, >=2)
CNT_W, 16, width of hit/miss counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  freeze F/D stages this cycle
d_valid  in  1  D stage holds a real instruction (0 = bubble)
d_pc  in  32  PC of the D-stage instruction
npc_op  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG, 4 JAL; 5-7 treated as SEQ
br_take  in  1  D-stage comparator result for BRANCH
imm26  in  26  instruction immediate field
rs_data  in  32  forwarded rs value
jr_ra  in  1  JREG instruction uses rs == $31
f_pc  out  32  registered F-stage PC
npc  out  32  combinational next PC
ras_top  out  32  current RAS top (0 when empty)
ras_cnt  out  $clog2(RAS_DEPTH+1)  valid RAS entries
ras_hit_cnt  out  CNT_W  jr $ra pops where ras_top == rs_data
ras_miss_cnt  out  CNT_W  jr $ra pops that missed or hit an empty RAS
align_err  out  1  sticky misaligned-target flag (optional feature)
err_addr  out  32  first misaligned target (optional feature)

Behaviour:
- Reset (synchronous, active-high): f_pc=RESET_PC; RAS emptied (ras_cnt=0, ras_top=0); both counters=0; align_err=0; err_addr=0. Reset overrides stall and all other inputs.
- Effective op: if d_valid=0, treat as SEQ. Otherwise use npc_op.
- npc:
  - SEQ → f_pc+4.
  - BRANCH with br_take=1 → d_pc+4+{{14{imm26[15]}},imm26[15:0],2'b00}.
  - BRANCH with br_take=0 → f_pc+4.
  - JUMP/JAL → {d_pc[31:28],imm26,2'b00}.
  - JREG → rs_data.
  - All sums are mod 2^32.
- Delay slot: the instruction already fetched into F executes. The redirect only replaces the fetch after it. No flush output.
- Each rising edge with stall=0: f_pc<=npc. With stall=1: f_pc, RAS and counters hold, and no push or pop occurs.
- RAS push: on a non-stalled valid JAL, push d_pc+8.
  - RAS is circular. When full, the push overwrites the oldest entry and ras_cnt stays RAS_DEPTH.
- RAS pop: on a non-stalled valid JREG with jr_ra=1.
  - If ras_cnt>0 and ras_top==rs_data: hit, increment ras_hit_cnt.
  - Otherwise: miss, increment ras_miss_cnt.
  - If ras_cnt>0, pop. Popping an empty RAS leaves it empty.
  - npc is always rs_data. The RAS never redirects fetch.
- Counters saturate at all-ones.
- JAL and JREG cannot occur in the same cycle, so there is no simultaneous push and pop.
- ras_top and ras_cnt reflect registered state. A push is visible the cycle after the edge.

Optional Feature:
NPC_ALIGN_CHECK_EN
- Defined: when a valid, non-stalled JREG has rs_data[1:0]!=0:
  - align_err<=1, sticky until reset.
  - err_addr captures rs_data on the first occurrence only.
  - npc uses {rs_data[31:2],2'b00}.
- Undefined: align_err and err_addr are tied to 0, and JREG uses rs_data unmodified.

Test Plan:
- Reset, then 3 non-stalled cycles with SEQ/d_valid=1 → f_pc sequence 0x3000, 0x3004, 0x3008, 0x300C.
- d_pc=0x3010, BRANCH, imm26[15:0]=0xFFFC, br_take=1 → npc=0x3004. Same with br_take=0 and f_pc=0x3014 → npc=0x3018.
- Stall:
  - stall=1 for 2 cycles with JUMP imm26=0x0000C10 → f_pc holds.
  - Release stall → f_pc=0x00003040.
  - d_valid=0 with JUMP → npc=f_pc+4.
- JAL at d_pc=0x3020, then JREG jr_ra=1 with rs_data=0x3028 → ras_cnt goes 1 then 0, ras_hit_cnt=1. Repeat with rs_data=0x4000 → ras_miss_cnt=1.
- RAS_DEPTH+1 JALs at d_pc=0x3000+16k → ras_cnt=RAS_DEPTH, ras_top=d_pc_last+8. Popping all of them → RAS_DEPTH hits. One extra pop → miss, ras_cnt stays 0.
- With NPC_ALIGN_CHECK_EN: JREG rs_data=0x3006 → npc=0x3004, align_err=1, err_addr=0x3006. A second misaligned jr leaves err_addr unchanged. Reset clears both.
